// File: rtl/voice_command_scheduler.sv
// voice_command_scheduler
//   Filters raw detections from a speech-recognition engine into confirmed
//   commands, suppresses quick repeats of the last queued command, buffers up
//   to four commands and hands them one at a time to a control unit using a
//   req/ack handshake with a timeout.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   enable       1 = accept detections and start new dispatches
//   cmd_valid    single-cycle detection strobe
//   cmd_code     detected command code, 0x00 = no command
//   ctrl_req     request to the control unit (registered)
//   ctrl_cmd     command presented with ctrl_req (registered)
//   ctrl_ack     control unit accepted ctrl_cmd
//   err_clr      clears the sticky error flags
//   fifo_count   number of queued commands, 0..4 (registered)
//   busy         dispatcher active or queue non-empty (registered)
//   overflow     sticky: confirmed command dropped because the queue was full
//   timeout_err  sticky: command discarded after an ack timeout

module voice_command_scheduler #(
  parameter int unsigned CONFIRM_CNT    = 3,
  parameter int unsigned HOLDOFF_CYCLES = 1000,
  parameter int unsigned ACK_TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  output logic       ctrl_req,
  output logic [7:0] ctrl_cmd,
  input  logic       ctrl_ack,
  input  logic       err_clr,
  output logic [2:0] fifo_count,
  output logic       busy,
  output logic       overflow,
  output logic       timeout_err
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HOLD_W = 16;
  localparam int unsigned TMR_W  = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned FCNT_W = 3;

  localparam logic [CNT_W-1:0]  CONFIRM_V  = CNT_W'(CONFIRM_CNT);
  localparam logic [HOLD_W-1:0] HOLDOFF_V  = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [TMR_W-1:0]  TMO_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Confirmation stage
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;
  logic [CNT_W-1:0]  match_cnt_c;
  logic              accept_c;

  // Repeat suppression
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CODE_W-1:0] last_q, last_d;
  logic              push_req_c;

  // Queue
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              push_c;
  logic              pop_c;
  logic              ovf_evt_c;

  // Dispatcher
  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              req_q, req_d;
  logic [CODE_W-1:0] cmd_q, cmd_d;
  logic              tmo_evt_c;

  // Flags
  logic              ovf_q, ovf_d;
  logic              tmo_q, tmo_d;
  logic              busy_q, busy_d;

  // Count consecutive identical detections; accept when the run is long enough
  always_comb begin
    cand_d      = cand_q;
    mcnt_d      = mcnt_q;
    accept_c    = 1'b0;
    match_cnt_c = CNT_W'(1);
    if (!enable) begin
      cand_d = '0;
      mcnt_d = '0;
    end else if (cmd_valid && (cmd_code != '0)) begin
      // candidate is only ever nonzero, so 0x00 never matches a real code
      if (cmd_code == cand_q) begin
        match_cnt_c = mcnt_q + CNT_W'(1);
      end
      if (match_cnt_c == CONFIRM_V) begin
        accept_c = 1'b1;
        cand_d   = '0;
        mcnt_d   = '0;
      end else begin
        cand_d = cmd_code;
        mcnt_d = match_cnt_c;
      end
    end
  end

  // Drop a confirmed code that repeats the last queued one inside the holdoff window
  always_comb begin
    push_req_c = accept_c && !((cmd_code == last_q) && (hold_q != '0));
  end

  // Dispatch FSM: present head of queue, wait for ack or timeout, then one gap cycle
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    req_d     = req_q;
    cmd_d     = cmd_q;
    pop_c     = 1'b0;
    tmo_evt_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if ((fcnt_q != '0) && enable) begin
          state_d = ISSUE;
          req_d   = 1'b1;
          cmd_d   = mem_q[rd_ptr_q];
          tmr_d   = '0;
        end
      end
      ISSUE: begin
        // an ack in the final cycle still wins over the timeout
        if (ctrl_ack) begin
          pop_c   = 1'b1;
          state_d = GAP;
          req_d   = 1'b0;
        end else if (tmr_q == TMO_LAST) begin
          pop_c     = 1'b1;
          tmo_evt_c = 1'b1;
          state_d   = GAP;
          req_d     = 1'b0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      GAP: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Queue bookkeeping; a pop in the same cycle frees the slot for a push when full
  always_comb begin
    push_c    = push_req_c && ((fcnt_q != FIFO_FULL) || pop_c);
    ovf_evt_c = push_req_c && !push_c;
    wr_ptr_d  = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push_c, pop_c})
      2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  // Holdoff timer reloads on every push and saturates at zero
  always_comb begin
    last_d = last_q;
    if (push_c) begin
      last_d = cmd_code;
      hold_d = HOLDOFF_V;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else begin
      hold_d = '0;
    end
  end

  // Sticky flags: a set event in the same cycle beats err_clr
  always_comb begin
    ovf_d  = ovf_evt_c ? 1'b1 : (err_clr ? 1'b0 : ovf_q);
    tmo_d  = tmo_evt_c ? 1'b1 : (err_clr ? 1'b0 : tmo_q);
    busy_d = (state_d != IDLE) || (fcnt_d != '0);
  end

  // Queue storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= cmd_code;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q   <= '0;
      mcnt_q   <= '0;
      hold_q   <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      tmr_q    <= '0;
      req_q    <= 1'b0;
      cmd_q    <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      mcnt_q   <= mcnt_d;
      hold_q   <= hold_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      req_q    <= req_d;
      cmd_q    <= cmd_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
    end
  end

  assign ctrl_req    = req_q;
  assign ctrl_cmd    = cmd_q;
  assign fifo_count  = fcnt_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_voice_command_scheduler.sv
// Testbench for voice_command_scheduler: directed stimulus, a queue-based
// reference model updated every clock, a per-cycle compare process and
// hand-computed literal checks at the key points of each scenario.

module tb_voice_command_scheduler;

  localparam int C = 3;
  localparam int H = 40;
  localparam int T = 64;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       ctrl_req;
  logic [7:0] ctrl_cmd;
  logic       ctrl_ack;
  logic       err_clr;
  logic [2:0] fifo_count;
  logic       busy;
  logic       overflow;
  logic       timeout_err;

  voice_command_scheduler #(
    .CONFIRM_CNT   (C),
    .HOLDOFF_CYCLES(H),
    .ACK_TIMEOUT   (T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .ctrl_req   (ctrl_req),
    .ctrl_cmd   (ctrl_cmd),
    .ctrl_ack   (ctrl_ack),
    .err_clr    (err_clr),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cand, m_cnt, m_last, m_hold;
  int m_q[$];
  int m_phase;   // 0 idle, 1 issuing, 2 gap
  int m_age;     // issuing cycles elapsed
  int m_req, m_cmd, m_ovf, m_tmo, m_busy;

  always @(posedge clk) begin
    int  acc;
    bit  pop, tmo_evt, ovf_evt, pushed;
    if (reset) begin
      m_cand = 0; m_cnt = 0; m_last = 0; m_hold = 0;
      m_q.delete();
      m_phase = 0; m_age = 0;
      m_req = 0; m_cmd = 0; m_ovf = 0; m_tmo = 0; m_busy = 0;
    end else begin
      acc = -1;
      if (!enable) begin
        m_cand = 0; m_cnt = 0;
      end else if (cmd_valid && cmd_code != 8'h00) begin
        if (int'(cmd_code) == m_cand) m_cnt++;
        else begin m_cand = int'(cmd_code); m_cnt = 1; end
        if (m_cnt == C) begin acc = int'(cmd_code); m_cand = 0; m_cnt = 0; end
      end
      pop = 0; tmo_evt = 0;
      case (m_phase)
        0: if (m_q.size() > 0 && enable) begin
             m_phase = 1; m_req = 1; m_cmd = m_q[0]; m_age = 0;
           end
        1: begin
             m_age++;
             if (ctrl_ack) pop = 1;
             else if (m_age >= T) begin pop = 1; tmo_evt = 1; end
             if (pop) begin m_phase = 2; m_req = 0; end
           end
        default: m_phase = 0;
      endcase
      if (pop) void'(m_q.pop_front());
      pushed = 0; ovf_evt = 0;
      if (acc >= 0 && !(acc == m_last && m_hold > 0)) begin
        if (m_q.size() < 4) begin m_q.push_back(acc); pushed = 1; m_last = acc; end
        else ovf_evt = 1;
      end
      if (pushed) m_hold = H;
      else if (m_hold > 0) m_hold--;
      if (ovf_evt) m_ovf = 1; else if (err_clr) m_ovf = 0;
      if (tmo_evt) m_tmo = 1; else if (err_clr) m_tmo = 0;
      m_busy = (m_phase != 0 || m_q.size() != 0) ? 1 : 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ctrl_req",    int'(ctrl_req),    m_req);
      chk("m_ctrl_cmd",    int'(ctrl_cmd),    m_cmd);
      chk("m_fifo_count",  int'(fifo_count),  m_q.size());
      chk("m_busy",        int'(busy),        m_busy);
      chk("m_overflow",    int'(overflow),    m_ovf);
      chk("m_timeout_err", int'(timeout_err), m_tmo);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; applies inputs for one clock and returns at the next negedge.
  task automatic cyc(input logic v, input logic [7:0] c, input logic a, input logic clr);
    cmd_valid = v; cmd_code = c; ctrl_ack = a; err_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic strobe(input logic [7:0] c);
    cyc(1'b1, c, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_req(input int max_cyc);
    int n;
    n = 0;
    while (ctrl_req !== 1'b1 && n < max_cyc) begin idle(1); n++; end
    checks++;
    if (ctrl_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_req: ctrl_req=%0b after %0d cycles, expected 1", ctrl_req, n);
    end
  endtask

  task automatic wait_drop(input int max_cyc);
    int n;
    n = 0;
    while (ctrl_req !== 1'b0 && n < max_cyc) begin idle(1); n++; end
    checks++;
    if (ctrl_req !== 1'b0) begin
      errors++;
      $display("FAIL wait_drop: ctrl_req=%0b after %0d cycles, expected 0", ctrl_req, n);
    end
  endtask

  logic [7:0] burst [6];

  initial begin
    burst[0] = 8'h21; burst[1] = 8'h42; burst[2] = 8'h43;
    burst[3] = 8'h44; burst[4] = 8'h45; burst[5] = 8'h46;
    reset = 1'b1; enable = 1'b0;
    cmd_valid = 1'b0; cmd_code = 8'h00; ctrl_ack = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_ctrl_req", int'(ctrl_req), 0);
    chk("rst_ctrl_cmd", int'(ctrl_cmd), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'({overflow, timeout_err}), 0);
    reset = 1'b0; enable = 1'b1;
    idle(2);

    // Basic confirm + dispatch + ack
    strobe(8'h21); strobe(8'h21); strobe(8'h21);
    chk("basic_count", int'(fifo_count), 1);
    chk("basic_req", int'(ctrl_req), 1);
    chk("basic_cmd", int'(ctrl_cmd), 8'h21);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ack_req", int'(ctrl_req), 0);
    chk("ack_count", int'(fifo_count), 0);
    idle(1);
    chk("ack_busy", int'(busy), 0);

    // Holdoff: repeat suppressed, different code passes
    strobe(8'h21); strobe(8'h21); strobe(8'h21);
    chk("hold_count", int'(fifo_count), 0);
    chk("hold_req", int'(ctrl_req), 0);
    strobe(8'h30); strobe(8'h30); strobe(8'h30);
    chk("hold_other_req", int'(ctrl_req), 1);
    chk("hold_other_cmd", int'(ctrl_cmd), 8'h30);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Interrupted run restarts the candidate
    strobe(8'h21); strobe(8'h21); strobe(8'h05); strobe(8'h21);
    chk("restart_count0", int'(fifo_count), 0);
    strobe(8'h21);
    chk("restart_count1", int'(fifo_count), 0);
    strobe(8'h21);
    chk("restart_push", int'(fifo_count), 1);
    chk("restart_cmd", int'(ctrl_cmd), 8'h21);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Holdoff expiry re-enables the same code
    idle(H + 5);
    strobe(8'h21); strobe(8'h21); strobe(8'h21);
    chk("expire_count", int'(fifo_count), 1);
    chk("expire_cmd", int'(ctrl_cmd), 8'h21);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(H + 5);

    // Overflow and ack timeout
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < C; j++) cyc(1'b1, burst[k], 1'b0, 1'b0);
    idle(1);
    chk("ovf_count", int'(fifo_count), 4);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_tmo", int'(timeout_err), 0);
    wait_drop(T + 10);
    chk("tmo_flag", int'(timeout_err), 1);
    chk("tmo_count", int'(fifo_count), 3);
    wait_req(5);
    chk("tmo_next_cmd", int'(ctrl_cmd), 8'h42);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_flags", int'({overflow, timeout_err}), 0);

    // Full queue: confirming push coincident with ack pop
    for (int j = 0; j < C; j++) cyc(1'b1, 8'h47, 1'b0, 1'b0);
    chk("full_count", int'(fifo_count), 4);
    cyc(1'b1, 8'h48, 1'b0, 1'b0);
    cyc(1'b1, 8'h48, 1'b0, 1'b0);
    cyc(1'b1, 8'h48, 1'b1, 1'b0);
    chk("pushpop_count", int'(fifo_count), 4);
    chk("pushpop_ovf", int'(overflow), 0);
    wait_req(5);
    chk("pushpop_next", int'(ctrl_cmd), 8'h43);
    // err_clr on the timeout cycle: set wins
    idle(T - 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_vs_tmo", int'(timeout_err), 1);
    chk("clr_vs_tmo_req", int'(ctrl_req), 0);
    chk("clr_vs_tmo_cnt", int'(fifo_count), 3);

    // Reset mid-issue
    wait_req(5);
    chk("pre_rst_cmd", int'(ctrl_cmd), 8'h44);
    chk("pre_rst_count", int'(fifo_count), 3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("midrst_req", int'(ctrl_req), 0);
    chk("midrst_count", int'(fifo_count), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_flags", int'({overflow, timeout_err}), 0);
    idle(2);

    // enable=0 clears the candidate and blocks dispatch
    strobe(8'h66); strobe(8'h66);
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    strobe(8'h66);
    chk("en_clear_count", int'(fifo_count), 0);
    strobe(8'h66);
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    enable = 1'b0;
    idle(3);
    chk("en_block_count", int'(fifo_count), 1);
    chk("en_block_req", int'(ctrl_req), 0);
    enable = 1'b1;
    wait_req(5);
    chk("en_resume_cmd", int'(ctrl_cmd), 8'h66);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(3);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
